// File: rtl/tx_pkt_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkt_pkg
// Shared definitions for the tx_pkt_gen frame source:
//   - state_e     : generator FSM states
//   - PREAMBLE0/1 : the two preamble/SFD words
//   - MIN_LEN, MAX_LEN, MIN_GAP : frame length and gap clamp limits
//   - CRC_POLY, CRC_INIT        : reflected Ethernet CRC-32 constants
//   - clamp_len, clamp_gap, frame_byte : small helpers used by the top level
// -----------------------------------------------------------------------------
package tx_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE0,
        ST_PRE1,
        ST_FRAME,
        ST_GAP
    } state_e;

    localparam logic [31:0] PREAMBLE0 = 32'h5555_5555;
    localparam logic [31:0] PREAMBLE1 = 32'h5555_55D5;

    localparam logic [10:0] MIN_LEN = 11'd64;
    localparam logic [10:0] MAX_LEN = 11'd1518;
    localparam logic [7:0]  MIN_GAP = 8'd3;

    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len < MIN_LEN)      return MIN_LEN;
        else if (len > MAX_LEN) return MAX_LEN;
        else                    return len;
    endfunction

    function automatic logic [7:0] clamp_gap(input logic [7:0] gap);
        return (gap < MIN_GAP) ? MIN_GAP : gap;
    endfunction

    // Content of frame byte b when it is not an FCS byte: DA, SA, EtherType,
    // then the incrementing payload pattern (b-14) mod 256.
    function automatic logic [7:0] frame_byte(input logic [10:0] b,
                                              input logic [47:0] da,
                                              input logic [47:0] sa,
                                              input logic [15:0] etype);
        logic [47:0] tmp;
        logic [2:0]  idx;
        if (b < 11'd6) begin
            tmp = da << {b[2:0], 3'b000};
            return tmp[47:40];
        end else if (b < 11'd12) begin
            idx = 3'(b - 11'd6);
            tmp = sa << {idx, 3'b000};
            return tmp[47:40];
        end else if (b < 11'd14) begin
            return (b == 11'd12) ? etype[15:8] : etype[7:0];
        end else begin
            return 8'(b - 11'd14);
        end
    endfunction

endpackage

// File: rtl/tx_pkt_gen_if.sv
// -----------------------------------------------------------------------------
// tx_pkt_gen_if
// Word stream between the packet generator and the TX gearbox.
//   gen_en      : word-advance strobe from the gearbox
//   int_data_o  : 32-bit word, byte 0 on [31:24]
//   int_valid_o : word valid
//   int_sop_o   : first preamble word
//   int_eop_o   : last frame word
//   int_mod_o   : valid bytes in the eop word modulo 4 (00 = all four)
// master = generator side, slave = gearbox side.
// -----------------------------------------------------------------------------
interface tx_pkt_gen_if;
    logic        gen_en;
    logic [31:0] int_data_o;
    logic        int_valid_o;
    logic        int_sop_o;
    logic        int_eop_o;
    logic [1:0]  int_mod_o;

    modport master (
        input  gen_en,
        output int_data_o, int_valid_o, int_sop_o, int_eop_o, int_mod_o
    );

    modport slave (
        output gen_en,
        input  int_data_o, int_valid_o, int_sop_o, int_eop_o, int_mod_o
    );
endinterface

// File: rtl/crc32_byte_step.sv
// -----------------------------------------------------------------------------
// crc32_byte_step
// Combinational single-byte update of a reflected CRC-32 register
// (polynomial CRC_POLY). Only exists when TX_GEN_FCS_EN is defined.
//   crc_i  : current CRC register
//   data_i : byte to absorb
//   crc_o  : updated CRC register
// -----------------------------------------------------------------------------
`ifdef TX_GEN_FCS_EN
module crc32_byte_step
    import tx_pkt_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    always_comb begin
        logic [31:0] c;
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule
`endif

// File: rtl/tx_pkt_gen.sv
// -----------------------------------------------------------------------------
// tx_pkt_gen
// Ethernet frame source for the TX gearbox. Emits preamble/SFD, DA, SA,
// EtherType, incrementing payload and FCS as 32-bit words, advancing exactly
// one word per gen_en pulse and holding all outputs between pulses.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start / stop  : arm generation (IDLE only) / finish after current frame+gap
//   cfg_da/sa     : MAC addresses          cfg_type : EtherType
//   cfg_len       : frame bytes DA..FCS    cfg_gap  : idle words after frame
//   cfg_pkt_num   : frames to send, 0 = continuous
//   gen_if        : word stream (tx_pkt_gen_if.master)
//   busy          : not IDLE               pkt_cnt  : frames completed
//
// Build option TX_GEN_FCS_EN: when defined, the last four frame bytes carry the
// Ethernet CRC-32; otherwise they continue the payload pattern.
// -----------------------------------------------------------------------------
module tx_pkt_gen
    import tx_pkt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [47:0]         cfg_da,
    input  logic [47:0]         cfg_sa,
    input  logic [15:0]         cfg_type,
    input  logic [10:0]         cfg_len,
    input  logic [7:0]          cfg_gap,
    input  logic [15:0]         cfg_pkt_num,
    tx_pkt_gen_if.master        gen_if,
    output logic                busy,
    output logic [15:0]         pkt_cnt
);

    state_e      state_q;
    logic        start_q, stop_q;
    logic [31:0] data_q;
    logic        valid_q, sop_q, eop_q;
    logic [1:0]  mod_q;
    logic [15:0] pkt_cnt_q;
    logic [8:0]  word_q;
    logic [7:0]  gap_cnt_q;

    // Per-frame configuration snapshot
    logic [47:0] da_q, sa_q;
    logic [15:0] type_q;
    logic [10:0] len_q;
    logic [7:0]  gap_q;
    logic [15:0] pkt_num_q;

    logic        armed, gap_last, finish, pre0_go;
    logic [8:0]  last_word, word_idx_d;
    logic [10:0] lane_b    [4];
    logic [7:0]  lane_byte [4];
    logic [3:0]  lane_frame;
    logic [31:0] word_data_d;

    assign armed     = start_q | start;
    assign gap_last  = (gap_cnt_q == gap_q);
    assign finish    = stop_q | stop |
                       ((pkt_num_q != 16'd0) && ((pkt_cnt_q + 16'd1) == pkt_num_q));
    assign pre0_go   = ((state_q == ST_IDLE) && armed) ||
                       ((state_q == ST_GAP) && gap_last && !finish);
    assign last_word = 9'((len_q - 11'd1) >> 2);

    // Word index and byte lanes of the word the next gen_en will emit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        word_idx_d = (state_q == ST_PRE1) ? 9'd0 : word_q + 9'd1;
        lane_frame = '0;
        for (int k = 0; k < 4; k++) begin
            lane_b[k]     = {word_idx_d, 2'b00} + 11'(k);
            lane_frame[k] = lane_b[k] < len_q;
            lane_byte[k]  = frame_byte(lane_b[k], da_q, sa_q, type_q);
        end
    end

`ifdef TX_GEN_FCS_EN
    logic [31:0] crc_q;
    logic [31:0] crc_base, crc_word, fcs_word;
    logic [3:0]  lane_data;

    assign crc_base = (state_q == ST_PRE1) ? CRC_INIT : crc_q;

    always_comb begin
        lane_data = '0;
        for (int k = 0; k < 4; k++) begin
            lane_data[k] = lane_b[k] < (len_q - 11'd4);
        end
    end

    // Four cascaded byte steps; lanes past the covered range pass the CRC
    // through, so a word straddling payload and FCS sees the final CRC.
    for (genvar k = 0; k < 4; k++) begin : g_crc
        logic [31:0] c_in, c_step, c_out;
        if (k == 0) begin : g_first
            assign c_in = crc_base;
        end else begin : g_next
            assign c_in = g_crc[k-1].c_out;
        end
        crc32_byte_step u_step (
            .crc_i  (c_in),
            .data_i (lane_byte[k]),
            .crc_o  (c_step)
        );
        assign c_out = lane_data[k] ? c_step : c_in;
    end

    assign crc_word = g_crc[3].c_out;
    assign fcs_word = ~crc_word;

    always_comb begin
        logic [1:0] sel;
        word_data_d = '0;
        for (int k = 0; k < 4; k++) begin
            // FCS bytes go out LSB first; (b - len) mod 4 is the FCS byte index.
            sel = 2'(lane_b[k] - len_q);
            if (lane_frame[k]) begin
                word_data_d[31-8*k -: 8] = lane_data[k] ? lane_byte[k]
                                                        : 8'(fcs_word >> {sel, 3'b000});
            end
        end
    end
`else
    always_comb begin
        word_data_d = '0;
        for (int k = 0; k < 4; k++) begin
            if (lane_frame[k]) word_data_d[31-8*k -: 8] = lane_byte[k];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            mod_q     <= '0;
            pkt_cnt_q <= '0;
            word_q    <= '0;
            gap_cnt_q <= '0;
            da_q      <= '0;
            sa_q      <= '0;
            type_q    <= '0;
            len_q     <= MIN_LEN;
            gap_q     <= MIN_GAP;
            pkt_num_q <= '0;
`ifdef TX_GEN_FCS_EN
            crc_q     <= CRC_INIT;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if ((state_q == ST_IDLE) && start) start_q <= 1'b1;
            if ((state_q != ST_IDLE) && stop)  stop_q  <= 1'b1;

            if (gen_if.gen_en) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (armed) begin
                            pkt_cnt_q <= '0;
                            start_q   <= 1'b0;
                        end
                    end
                    ST_PRE0: begin
                        state_q <= ST_PRE1;
                        data_q  <= PREAMBLE1;
                        sop_q   <= 1'b0;
                    end
                    ST_PRE1, ST_FRAME: begin
                        if ((state_q == ST_FRAME) && (word_q == last_word)) begin
                            state_q   <= ST_GAP;
                            data_q    <= '0;
                            valid_q   <= 1'b0;
                            eop_q     <= 1'b0;
                            mod_q     <= '0;
                            gap_cnt_q <= 8'd1;
                        end else begin
                            state_q <= ST_FRAME;
                            word_q  <= word_idx_d;
                            data_q  <= word_data_d;
                            valid_q <= 1'b1;
                            eop_q   <= (word_idx_d == last_word);
                            mod_q   <= (word_idx_d == last_word) ? len_q[1:0] : 2'b00;
`ifdef TX_GEN_FCS_EN
                            crc_q   <= crc_word;
`endif
                        end
                    end
                    ST_GAP: begin
                        if (gap_last) begin
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                            if (finish) begin
                                state_q <= ST_IDLE;
                                stop_q  <= 1'b0;
                            end
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase

                // Start of a new frame: snapshot the configuration and emit PRE0.
                if (pre0_go) begin
                    state_q   <= ST_PRE0;
                    data_q    <= PREAMBLE0;
                    valid_q   <= 1'b1;
                    sop_q     <= 1'b1;
                    eop_q     <= 1'b0;
                    mod_q     <= '0;
                    da_q      <= cfg_da;
                    sa_q      <= cfg_sa;
                    type_q    <= cfg_type;
                    len_q     <= clamp_len(cfg_len);
                    gap_q     <= clamp_gap(cfg_gap);
                    pkt_num_q <= cfg_pkt_num;
                end
            end
        end
    end

    assign gen_if.int_data_o  = data_q;
    assign gen_if.int_valid_o = valid_q;
    assign gen_if.int_sop_o   = sop_q;
    assign gen_if.int_eop_o   = eop_q;
    assign gen_if.int_mod_o   = mod_q;
    assign busy               = (state_q != ST_IDLE);
    assign pkt_cnt            = pkt_cnt_q;

endmodule

// File: doc/tx_pkt_gen.md
# tx_pkt_gen

Upstream packet source for the TX gearbox. Builds complete Ethernet frames as a 32-bit word stream: preamble/SFD, DA, SA, EtherType, incrementing-byte payload and FCS. It advances exactly one word per `gen_en` pulse from the gearbox and holds every output stable between pulses, so the gearbox can sample the word at any point of its 4-cycle (1G) or 8-cycle (100M/10M) window.

## Interface
Parameters:
- none; all frame content is set by the `cfg_*` inputs.

Ports:
- `clk` in 1: single clock, shared with the gearbox.
- `rst` in 1: reset, synchronous, active-high.
- `gen_en` in 1: word-advance strobe from the gearbox.
- `start` in 1: pulse that arms generation; ignored unless IDLE.
- `stop` in 1: pulse that ends generation after the current frame and gap.
- `cfg_da` in 48: destination MAC.
- `cfg_sa` in 48: source MAC.
- `cfg_type` in 16: EtherType.
- `cfg_len` in 11: frame length in bytes, DA through FCS.
- `cfg_gap` in 8: idle words after each frame.
- `cfg_pkt_num` in 16: number of frames to send; 0 means continuous.
- `int_data_o` out 32: word data; byte 0 is on [31:24].
- `int_valid_o` out 1: word valid.
- `int_sop_o` out 1: first preamble word.
- `int_eop_o` out 1: last frame word.
- `int_mod_o` out 2: valid bytes in the eop word, modulo 4; 00 means all 4 bytes.
- `busy` out 1: high in every state except IDLE.
- `pkt_cnt` out 16: frames completed since `start`.

## Operation
- States: IDLE, PRE0, PRE1, FRAME, GAP. All state transitions and output updates happen only on clocks where `gen_en`=1.
- IDLE: a `start` seen (latched) arms the block. The next `gen_en` enters PRE0 and clears `pkt_cnt`.
- Config sampling: all `cfg_*` inputs are sampled on entry to PRE0, i.e. once per frame.
- Length clamp: L = clamp(`cfg_len`, 64, 1518).
- Gap clamp: G = max(`cfg_gap`, 3).
- PRE0 emits 0x55555555 with sop=1. PRE1 emits 0x555555D5.
- FRAME emits N = ceil(L/4) words. Byte index b = 0..L-1 maps as:
  - b<6: DA, MSB first.
  - b<12: SA, MSB first.
  - b<14: EtherType.
  - b<L-4: payload byte (b-14) mod 256.
  - else: FCS byte.
- Last FRAME word: eop=1, mod = L mod 4. Unused byte lanes are 0x00.
- GAP emits G words with valid=0 and data 0.
- After GAP:
  - `pkt_cnt`++.
  - If stop was latched, or `pkt_cnt` has reached a nonzero `cfg_pkt_num`: go to IDLE and clear the stop latch.
  - Otherwise go to PRE0.
- `stop` while IDLE is ignored. `start` while busy is ignored.
- `pkt_cnt` wraps at 16 bits.

## Timing
- Latency: outputs are registered and change on the clock edge where `gen_en`=1. They are held unchanged on all other clocks.
- The block is agnostic to the `gen_en` period; it requires only ≥2 clocks between pulses.
- FCS for a word that straddles payload and FCS is computed combinationally within the same update, so no extra latency.
- Reset values: all outputs 0, state IDLE, start/stop latches cleared.
- Reset mid-frame: outputs are 0 on the next clock. No partial frame resumes.

## Configuration
- `TX_GEN_FCS_EN` defined:
  - FCS is standard Ethernet CRC-32: reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement, LSB byte first.
  - It covers bytes 0..L-5.
- `TX_GEN_FCS_EN` undefined:
  - No CRC logic.
  - The last 4 bytes continue the payload pattern, (b-14) mod 256.

## Structure
- Package `tx_pkt_pkg` holds:
  - the state enum;
  - PREAMBLE0/1 constants;
  - MIN_LEN 64, MAX_LEN 1518, MIN_GAP 3;
  - CRC_POLY and CRC_INIT.
- Sub-module `crc32_byte_step`: combinational single-byte CRC update, cascaded 4× for masked word updates. Instantiated only under `TX_GEN_FCS_EN`.

## Test plan
- Single 64-byte frame, FCS enabled. Stimulus: `cfg_len`=64, `cfg_pkt_num`=1, `cfg_gap`=3, DA=FF:FF:FF:FF:FF:FF, SA=00:01:02:03:04:05, type=0x0800, `start`. Required response:
  - Words: 55555555 (sop), 555555D5, FFFFFFFF, FFFF0001, 02030405, 08000001, and so on.
  - eop on word 18, mod=00.
  - Reflected CRC register over all 64 frame bytes (FCS included, without final complement) equals residue 0xDEBB20E3.
  - Then 3 idle words, `busy`→0, `pkt_cnt`=1.
- Odd length: `cfg_len`=65 → 17 frame words, eop mod=01. The FCS straddles words 16/17 and the residue check passes.
- Clamping:
  - `cfg_len`=10 → 64-byte frame.
  - `cfg_len`=2000 → 1518 bytes, 380 frame words, mod=10.
  - `cfg_gap`=0 → 3 idle words.
- Frame count: `cfg_pkt_num`=3, `cfg_gap`=5 → exactly 3 frames, each separated by 5 invalid words; final `pkt_cnt`=3, `busy` drops after the last gap.
- Stop and reset:
  - Continuous mode, `stop` pulsed during a frame's payload → that frame and its gap complete, then IDLE.
  - `rst` asserted mid-frame → all outputs 0 on the next clock.
- Hold behaviour: `gen_en` held low for 20 clocks mid-frame → outputs bit-identical throughout. The stream then resumes with the next word, with none skipped.
